// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL_2X lock supervisor: software-visible state encoding
// and the retry counter width.
package pll_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF       = 3'd0,
    ST_PD_HOLD   = 3'd1,
    ST_LOCK_WAIT = 3'd2,
    ST_FILTER    = 3'd3,
    ST_RUN       = 3'd4,
    ST_LOST      = 3'd5,
    ST_RETRY     = 3'd6,
    ST_FAULT     = 3'd7
  } pll_state_e;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for an asynchronous status bit, synchronous active-high reset.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pll_2x_lock_ctrl.sv
// Power-up and lock supervisor for PLL_2X: sequences powerdown/release, filters
// LOCK, gates the downstream reset and retries lost or late locks before faulting.
module pll_2x_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned PD_CYCLES           = 8,
  parameter int unsigned LOCK_FILTER_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic               CLKA,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic               PLL_LOCK,
  input  logic               CLR_FAULT,
  output logic               PLL_POWERDOWN_N,
  output logic               SYS_RESET,
  output logic               READY,
  output logic               FAULT,
  output logic [RETRY_W-1:0] RETRY_CNT,
  output logic [STATE_W-1:0] STATE
);

  localparam logic [CNT_W-1:0]   PD_LAST   = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   FLT_LAST  = CNT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  pll_state_e         r_state;
  pll_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_pd_cnt, w_pd_nxt;
  logic [CNT_W-1:0]   r_tmo_cnt, w_tmo_nxt;
  logic [CNT_W-1:0]   r_flt_cnt, w_flt_nxt;
  logic [RETRY_W-1:0] r_retry_cnt, w_retry_nxt;
  logic               r_pd_n, r_sys_reset, r_ready, r_fault;
  logic               w_lock_s;

  pll_lock_sync u_lock_sync (
    .clk     (CLKA),
    .rst     (RESET),
    .i_async (PLL_LOCK),
    .o_sync  (w_lock_s)
  );

  // Next-state and counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_pd_nxt    = r_pd_cnt;
    w_tmo_nxt   = r_tmo_cnt;
    w_flt_nxt   = r_flt_cnt;
    w_retry_nxt = r_retry_cnt;

    if (r_state == ST_FAULT) begin
      if (CLR_FAULT) begin
        w_state_nxt = ST_OFF;
        w_retry_nxt = '0;
      end
    end else if (!ENABLE) begin
      w_state_nxt = ST_OFF;
      w_pd_nxt    = '0;
      w_tmo_nxt   = '0;
      w_flt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_PD_HOLD;
          w_pd_nxt    = '0;
        end
        ST_PD_HOLD: begin
          if (r_pd_cnt == PD_LAST) begin
            w_state_nxt = ST_LOCK_WAIT;
            w_tmo_nxt   = '0;
          end else begin
            w_pd_nxt = r_pd_cnt + CNT_ONE;
          end
        end
        ST_LOCK_WAIT: begin
          w_tmo_nxt = r_tmo_cnt + CNT_ONE;
          if (r_tmo_cnt == TMO_LAST) begin
            w_state_nxt = ST_RETRY;
          end else if (w_lock_s) begin
            w_state_nxt = ST_FILTER;
            w_flt_nxt   = '0;
          end
        end
        ST_FILTER: begin
          // Timeout is not reset on chatter, so a flapping LOCK still bounds the wait
          w_tmo_nxt = r_tmo_cnt + CNT_ONE;
          if (r_tmo_cnt == TMO_LAST) begin
            w_state_nxt = ST_RETRY;
          end else if (!w_lock_s) begin
            w_state_nxt = ST_LOCK_WAIT;
          end else if (r_flt_cnt == FLT_LAST) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_flt_nxt = r_flt_cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!w_lock_s) w_state_nxt = ST_LOST;
        end
        ST_LOST: begin
          w_state_nxt = ST_RETRY;
        end
        ST_RETRY: begin
          if (r_retry_cnt == RETRY_MAX) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_state_nxt = ST_PD_HOLD;
            w_pd_nxt    = '0;
            if (r_retry_cnt != '1) w_retry_nxt = r_retry_cnt + RETRY_ONE;
          end
        end
        default: w_state_nxt = ST_OFF;
      endcase
    end
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge CLKA) begin
    if (RESET) begin
      r_state     <= ST_OFF;
      r_pd_cnt    <= '0;
      r_tmo_cnt   <= '0;
      r_flt_cnt   <= '0;
      r_retry_cnt <= '0;
      r_pd_n      <= 1'b0;
      r_sys_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pd_cnt    <= w_pd_nxt;
      r_tmo_cnt   <= w_tmo_nxt;
      r_flt_cnt   <= w_flt_nxt;
      r_retry_cnt <= w_retry_nxt;
      r_pd_n      <= (w_state_nxt == ST_LOCK_WAIT) || (w_state_nxt == ST_FILTER) ||
                     (w_state_nxt == ST_RUN)       || (w_state_nxt == ST_LOST);
      r_sys_reset <= (w_state_nxt != ST_RUN);
      r_ready     <= (w_state_nxt == ST_RUN);
      r_fault     <= (w_state_nxt == ST_FAULT);
    end
  end

  assign PLL_POWERDOWN_N = r_pd_n;
  assign SYS_RESET       = r_sys_reset;
  assign READY           = r_ready;
  assign FAULT           = r_fault;
  assign RETRY_CNT       = r_retry_cnt;
  assign STATE           = r_state;

endmodule

// File: tb/tb_pll_2x_lock_ctrl.sv
// Bench for pll_2x_lock_ctrl: directed timeline checks plus randomized LOCK/ENABLE
// traffic compared every cycle against a cycle-level behavioural model.
module tb_pll_2x_lock_ctrl;

  localparam int PD  = 8;
  localparam int LFC = 16;
  localparam int LTC = 64;
  localparam int MR  = 2;

  localparam int S_OFF = 0, S_PDH = 1, S_LW = 2, S_FLT = 3,
                 S_RUN = 4, S_LOST = 5, S_RETRY = 6, S_FAULT = 7;

  logic       CLKA = 1'b0;
  logic       RESET, ENABLE, PLL_LOCK, CLR_FAULT;
  logic       PLL_POWERDOWN_N, SYS_RESET, READY, FAULT;
  logic [3:0] RETRY_CNT;
  logic [2:0] STATE;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // model state
  int m_st, m_pd, m_tmo, m_flt, m_retry;
  bit m_h1, m_h2, m_ls;

  always #5 CLKA = ~CLKA;

  pll_2x_lock_ctrl #(
    .PD_CYCLES(PD), .LOCK_FILTER_CYCLES(LFC), .LOCK_TIMEOUT_CYCLES(LTC),
    .MAX_RETRIES(MR), .CNT_W(16)
  ) dut (
    .CLKA(CLKA), .RESET(RESET), .ENABLE(ENABLE), .PLL_LOCK(PLL_LOCK),
    .CLR_FAULT(CLR_FAULT), .PLL_POWERDOWN_N(PLL_POWERDOWN_N), .SYS_RESET(SYS_RESET),
    .READY(READY), .FAULT(FAULT), .RETRY_CNT(RETRY_CNT), .STATE(STATE)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at t=%0t cyc=%0d: got %0d expected %0d", nm, $time, cyc, act, exp);
    end
  endtask

  // Behavioural model: LOCK seen by the supervisor is the input sampled two edges earlier
  always @(posedge CLKA) begin
    m_ls = m_h2;
    if (RESET) begin
      m_st = S_OFF; m_pd = 0; m_tmo = 0; m_flt = 0; m_retry = 0;
      m_h1 = 0; m_h2 = 0;
    end else begin
      m_h2 = m_h1;
      m_h1 = PLL_LOCK;
      if (m_st == S_FAULT) begin
        if (CLR_FAULT) begin m_st = S_OFF; m_retry = 0; end
      end else if (!ENABLE) begin
        m_st = S_OFF; m_pd = 0; m_tmo = 0; m_flt = 0; m_retry = 0;
      end else if (m_st == S_OFF) begin
        m_st = S_PDH; m_pd = 0;
      end else if (m_st == S_PDH) begin
        if (m_pd == PD - 1) begin m_st = S_LW; m_tmo = 0; end
        else m_pd++;
      end else if (m_st == S_LW || m_st == S_FLT) begin
        if (m_tmo == LTC - 1) m_st = S_RETRY;
        else if (m_st == S_LW && m_ls) begin m_st = S_FLT; m_flt = 0; end
        else if (m_st == S_FLT && !m_ls) m_st = S_LW;
        else if (m_st == S_FLT && m_flt == LFC - 1) m_st = S_RUN;
        else if (m_st == S_FLT) m_flt++;
        m_tmo++;
      end else if (m_st == S_RUN) begin
        if (!m_ls) m_st = S_LOST;
      end else if (m_st == S_LOST) begin
        m_st = S_RETRY;
      end else if (m_st == S_RETRY) begin
        if (m_retry == MR) m_st = S_FAULT;
        else begin
          m_st = S_PDH; m_pd = 0;
          if (m_retry < 15) m_retry++;
        end
      end
    end
  end

  // Per-cycle comparison shortly after each active edge
  always @(posedge CLKA) begin
    #1;
    if (chk_en) begin
      chk("state", int'(STATE), m_st);
      chk("pll_pd_n", int'(PLL_POWERDOWN_N), int'(m_st >= S_LW && m_st <= S_LOST));
      chk("sys_reset", int'(SYS_RESET), int'(m_st != S_RUN));
      chk("ready", int'(READY), int'(m_st == S_RUN));
      chk("fault", int'(FAULT), int'(m_st == S_FAULT));
      chk("retry_cnt", int'(RETRY_CNT), m_retry);
    end
  end

  task automatic next_cyc();
    @(negedge CLKA);
    cyc++;
  endtask

  task automatic start_seq(input bit en, input bit lk);
    @(negedge CLKA);
    ENABLE = en; PLL_LOCK = lk; CLR_FAULT = 1'b0; RESET = 1'b0;
    cyc = 0;
  endtask

  task automatic flush_off();
    @(negedge CLKA);
    ENABLE = 1'b0; PLL_LOCK = 1'b0; CLR_FAULT = 1'b0;
    repeat (4) @(negedge CLKA);
  endtask

  int mode, mode_left;

  initial begin
    RESET = 1'b1; ENABLE = 1'b0; PLL_LOCK = 1'b0; CLR_FAULT = 1'b0;
    repeat (3) @(negedge CLKA);
    chk("rst_state", int'(STATE), 0);
    chk("rst_pd_n", int'(PLL_POWERDOWN_N), 0);
    chk("rst_sys_reset", int'(SYS_RESET), 1);
    chk("rst_ready", int'(READY), 0);
    chk("rst_fault", int'(FAULT), 0);
    chk("rst_retry", int'(RETRY_CNT), 0);
    chk_en = 1'b1;

    // Nominal bring-up, then a one-cycle lock drop and re-lock
    start_seq(1'b1, 1'b1);
    for (int i = 0; i < 62; i++) begin
      next_cyc();
      if (cyc == 8)  chk("nom_pd_n_8", int'(PLL_POWERDOWN_N), 0);
      if (cyc == 9)  chk("nom_pd_n_9", int'(PLL_POWERDOWN_N), 1);
      if (cyc == 10) chk("nom_filter_10", int'(STATE), S_FLT);
      if (cyc == 25) chk("nom_ready_25", int'(READY), 0);
      if (cyc == 26) begin
        chk("nom_ready_26", int'(READY), 1);
        chk("nom_sysrst_26", int'(SYS_RESET), 0);
        chk("nom_retry_26", int'(RETRY_CNT), 0);
      end
      if (cyc == 30) PLL_LOCK = 1'b0;
      if (cyc == 31) PLL_LOCK = 1'b1;
      if (cyc == 32) chk("lost_ready_32", int'(READY), 1);
      if (cyc == 33) chk("lost_ready_33", int'(READY), 0);
      if (cyc == 34) chk("lost_pd_n_34", int'(PLL_POWERDOWN_N), 0);
      if (cyc == 35) chk("lost_retry_35", int'(RETRY_CNT), 1);
      if (cyc == 59) chk("relock_ready_59", int'(READY), 0);
      if (cyc == 60) chk("relock_ready_60", int'(READY), 1);
    end

    // ENABLE low from RUN clears the retry count
    @(negedge CLKA); ENABLE = 1'b0;
    next_cyc();
    chk("dis_state", int'(STATE), S_OFF);
    chk("dis_retry", int'(RETRY_CNT), 0);
    flush_off();

    // Lock chatter: 5 high, 3 low, then steady
    start_seq(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      next_cyc();
      if (cyc == 10) PLL_LOCK = 1'b1;
      if (cyc == 15) PLL_LOCK = 1'b0;
      if (cyc == 18) PLL_LOCK = 1'b1;
    end
    flush_off();

    // Timeout exhaustion into FAULT, ENABLE ignored, then clear
    start_seq(1'b1, 1'b0);
    for (int i = 0; i < 230; i++) begin
      next_cyc();
      if (cyc == 73)  chk("tmo1_retry_st", int'(STATE), S_RETRY);
      if (cyc == 74)  chk("tmo1_retry_cnt", int'(RETRY_CNT), 1);
      if (cyc == 147) chk("tmo2_retry_cnt", int'(RETRY_CNT), 2);
      if (cyc == 219) chk("tmo3_fault_219", int'(FAULT), 0);
      if (cyc == 220) begin
        chk("fault_st", int'(STATE), S_FAULT);
        chk("fault_flag", int'(FAULT), 1);
        chk("fault_pd_n", int'(PLL_POWERDOWN_N), 0);
        chk("fault_retry", int'(RETRY_CNT), 2);
        ENABLE = 1'b0;
      end
      if (cyc == 225) chk("fault_ign_en", int'(STATE), S_FAULT);
    end
    @(negedge CLKA); CLR_FAULT = 1'b1;
    next_cyc(); CLR_FAULT = 1'b0;
    chk("clr_state", int'(STATE), S_OFF);
    chk("clr_retry", int'(RETRY_CNT), 0);
    chk("clr_fault", int'(FAULT), 0);
    flush_off();

    // Lock one cycle before the boundary reaches RUN at edge 72
    start_seq(1'b1, 1'b0);
    for (int i = 0; i < 75; i++) begin
      next_cyc();
      if (cyc == 53) PLL_LOCK = 1'b1;
      if (cyc == 72) chk("edge_run_72", int'(STATE), S_RUN);
    end
    flush_off();

    // Filter and timeout expire together: RETRY wins
    start_seq(1'b1, 1'b0);
    for (int i = 0; i < 76; i++) begin
      next_cyc();
      if (cyc == 54) PLL_LOCK = 1'b1;
      if (cyc == 73) begin
        chk("tie_state", int'(STATE), S_RETRY);
        chk("tie_ready", int'(READY), 0);
      end
      if (cyc == 74) chk("tie_retry_cnt", int'(RETRY_CNT), 1);
    end

    // RESET mid PD_HOLD
    @(negedge CLKA); ENABLE = 1'b0;
    @(negedge CLKA); ENABLE = 1'b1;
    repeat (4) @(negedge CLKA);
    RESET = 1'b1;
    next_cyc();
    chk("rst_mid_state", int'(STATE), S_OFF);
    chk("rst_mid_pd_n", int'(PLL_POWERDOWN_N), 0);
    chk("rst_mid_sysrst", int'(SYS_RESET), 1);
    RESET = 1'b0;

    // Randomized traffic
    mode = 0; mode_left = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge CLKA);
      if (mode_left == 0) begin
        mode = $urandom_range(0, 3);
        mode_left = $urandom_range(10, 150);
      end
      mode_left--;
      case (mode)
        0:       PLL_LOCK = 1'b0;
        3:       PLL_LOCK = 1'($urandom_range(0, 1));
        default: PLL_LOCK = 1'b1;
      endcase
      if (ENABLE) ENABLE = ($urandom_range(0, 399) != 0);
      else        ENABLE = ($urandom_range(0, 9) == 0);
      CLR_FAULT = ($urandom_range(0, 59) == 0);
      RESET     = ($urandom_range(0, 1999) == 0);
    end

    @(negedge CLKA);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_2x_lock_ctrl.md
Name: pll_2x_lock_ctrl

Overview:
Power-up and lock supervisor for the PLL_2X clock generator that feeds the SDR controller.
- Sequences PLL powerdown and release.
- Qualifies LOCK with a synchronizer and a stability filter.
- Holds the downstream SDR/AHB logic in reset until the clock is good.
- Detects loss of lock, retries a bounded number of times, then reports a sticky fault.
- Runs on the free-running reference clock CLKA, never on GLA.

Parameters:
PD_CYCLES, 8, minimum cycles the PLL is held powered down before release (≥2)
LOCK_FILTER_CYCLES, 16, consecutive synchronized-LOCK-high cycles required to accept lock (≥1)
LOCK_TIMEOUT_CYCLES, 1024, max cycles from release to accepted lock before a retry (> LOCK_FILTER_CYCLES+2)
MAX_RETRIES, 3, retries allowed before FAULT (0..15)
CNT_W, 16, width of internal counters; must hold LOCK_TIMEOUT_CYCLES

Ports:
CLKA  in  1  reference clock, free-running
RESET  in  1  synchronous active-high reset
ENABLE  in  1  level; 1 = bring PLL up, 0 = power PLL down
PLL_LOCK  in  1  LOCK from PLL_2X, asynchronous to CLKA
CLR_FAULT  in  1  single-cycle pulse; clears the sticky fault
PLL_POWERDOWN_N  out  1  to PLL_2X POWERDOWN pin; active-low, 0 = PLL off
SYS_RESET  out  1  active-high reset to GLA-domain logic; the consumer resynchronizes deassertion
READY  out  1  1 only in RUN
FAULT  out  1  sticky retry-exhaustion flag
RETRY_CNT  out  4  retries consumed since last clear
STATE  out  3  current state encoding, for debug/APB status

Behaviour:
- One clock (CLKA). Reset is synchronous and active-high. All outputs are registered.
- RESET values:
  - state = OFF
  - PLL_POWERDOWN_N = 0, SYS_RESET = 1, READY = 0, FAULT = 0, RETRY_CNT = 0
  - synchronizer flops = 0, counters = 0
- LOCK path: two-flop synchronizer produces lock_s. PLL_LOCK is visible in lock_s 2 edges after the sampling edge.
- States, with encoding: OFF=0, PD_HOLD=1, LOCK_WAIT=2, FILTER=3, RUN=4, LOST=5, RETRY=6, FAULT_ST=7.
  - OFF: PLL off, SYS_RESET=1. ENABLE=1 → PD_HOLD, pd_cnt=0.
  - PD_HOLD: PLL off. pd_cnt increments. At pd_cnt == PD_CYCLES-1 → LOCK_WAIT; PLL_POWERDOWN_N rises on the same edge; tmo_cnt=0.
  - LOCK_WAIT: tmo_cnt increments. lock_s=1 → FILTER with flt_cnt=0.
  - FILTER: tmo_cnt keeps counting. lock_s=1 increments flt_cnt. lock_s=0 → LOCK_WAIT; tmo_cnt is NOT cleared, which bounds chatter. At flt_cnt == LOCK_FILTER_CYCLES-1 with lock_s=1 → RUN.
  - Timeout: in LOCK_WAIT or FILTER, tmo_cnt == LOCK_TIMEOUT_CYCLES-1 → RETRY. Timeout has priority over FILTER→RUN on the same cycle.
  - RUN: SYS_RESET=0 and READY=1, both registered on the RUN entry edge. lock_s=0 → LOST.
  - LOST: SYS_RESET=1, READY=0 on entry. Next cycle → RETRY.
  - RETRY: PLL_POWERDOWN_N=0 on entry.
    - If RETRY_CNT == MAX_RETRIES → FAULT_ST.
    - Else RETRY_CNT += 1 (saturating at 15) → PD_HOLD, pd_cnt=0.
  - FAULT_ST: FAULT=1, PLL off, SYS_RESET=1. Exits only on CLR_FAULT=1 → OFF, with FAULT=0 and RETRY_CNT=0. ENABLE is ignored in this state.
- Priority: RESET > CLR_FAULT (FAULT_ST only) > ENABLE=0 > normal transitions.
- ENABLE=0 in any state except FAULT_ST → OFF next edge. Effects: PLL_POWERDOWN_N=0, SYS_RESET=1, READY=0, RETRY_CNT=0, counters cleared.
- CLR_FAULT outside FAULT_ST has no effect.
- RETRY_CNT is not cleared on reaching RUN; it counts failures per enable session.
- SYS_RESET is 1 in every state except RUN. PLL_POWERDOWN_N is 1 only in LOCK_WAIT, FILTER, RUN and LOST.

Decomposition:
- Package pll_ctrl_pkg holds:
  - the state enum with the fixed 3-bit encoding above (STATE is software-visible);
  - the RETRY_CNT width constant.
- Sub-module pll_lock_sync is the 2-flop synchronizer with synchronous active-high reset, reusable for other async status bits.
- The FSM and counters stay in pll_2x_lock_ctrl.

Test Plan:
All scenarios use PD_CYCLES=8, LOCK_FILTER_CYCLES=16, LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=2.
1. Nominal bring-up: ENABLE rises at edge 0; PLL_LOCK rises at edge 20 and stays high → PLL_POWERDOWN_N=1 from edge 9; RUN entered at edge 38 (2-cycle sync plus 16 filter cycles after FILTER entry); SYS_RESET falls and READY rises there; RETRY_CNT=0.
2. Lock chatter: PLL_LOCK pulses high for 5 cycles, low 3, then stays high → FILTER is exited back to LOCK_WAIT at least once; RUN only after 16 uninterrupted lock_s cycles; READY never glitches high early.
3. Timeout and retry exhaustion: PLL_LOCK held 0 → three timeouts; RETRY_CNT goes 1, 2; FAULT=1, STATE=7, PLL_POWERDOWN_N=0; a CLR_FAULT pulse returns STATE=0 and RETRY_CNT=0.
4. Loss of lock in RUN: drop PLL_LOCK for 1 cycle → SYS_RESET=1 and READY=0 within 3 edges; PLL powered down for 8 cycles; RETRY_CNT=1; re-lock reaches RUN again.
5. ENABLE low mid-FILTER, then RESET asserted mid-PD_HOLD → OFF next edge with all outputs at reset values; RETRY_CNT cleared; no FAULT.
6. Simultaneous timeout and final filter cycle (lock_s stable from tmo_cnt=47 so both expire on edge 63) → RETRY taken, not RUN.
